// File: rtl/hazard_stall_mdu_pkg.sv
// hazard_pkg: shared types and constants for the D-stage stall controller.
package hazard_pkg;
    localparam int DEF_TW = 2;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef logic [DEF_TW-1:0] tTime;
endpackage

// File: rtl/hazard_stall_mdu_if.sv
// hazard_stall_mdu_if: pipeline-side signals of the stall controller.
interface hazard_stall_mdu_if import hazard_pkg::*; #(parameter int TW = DEF_TW);
    logic [31:0] D_inStr;
    logic [TW-1:0] D_TuseRs, D_TuseRt;
    logic D_isMD;
    logic [4:0] E_writeReg, M_writeReg;
    logic E_regWrite, M_regWrite;
    logic [TW-1:0] E_Tnew, M_Tnew;
    logic E_mdStart, E_mdIsDiv;
    logic F_pcWE, D_regWE, E_regclr, E_mdBusy;
    logic [31:0] stallCntData, stallCntMd;
    modport master (
        output D_inStr, D_TuseRs, D_TuseRt, D_isMD, E_writeReg, M_writeReg,
               E_regWrite, M_regWrite, E_Tnew, M_Tnew, E_mdStart, E_mdIsDiv,
        input  F_pcWE, D_regWE, E_regclr, E_mdBusy, stallCntData, stallCntMd
    );
    modport slave (
        input  D_inStr, D_TuseRs, D_TuseRt, D_isMD, E_writeReg, M_writeReg,
               E_regWrite, M_regWrite, E_Tnew, M_Tnew, E_mdStart, E_mdIsDiv,
        output F_pcWE, D_regWE, E_regclr, E_mdBusy, stallCntData, stallCntMd
    );
endinterface

// File: rtl/hazard_stall_mdu_md_busy_tracker.sv
// md_busy_tracker: counts down the multiply/divide latency after an MDU op enters E.
module md_busy_tracker #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CW = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mdStart,
    input  logic mdIsDiv,
    output logic mdBusy
);
    logic [CW-1:0] cnt;
    // A new start reloads even while a previous operation is still counting.
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (mdStart) cnt <= mdIsDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        else if (cnt != '0) cnt <= cnt - CW'(1);
    assign mdBusy = mdStart | (cnt != '0);
endmodule

// File: rtl/hazard_stall_mdu.sv
// hazard_stall_mdu: D-stage stall control from Tuse/Tnew hazards and MDU busy.
// Define HAZARD_STALL_PERF_EN to build the stall performance counters.
module hazard_stall_mdu import hazard_pkg::*; #(
    parameter int TW = DEF_TW,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int CW = 4
) (
    input logic clk,
    input logic reset,
    hazard_stall_mdu_if.slave bus
);
    logic [4:0] dRs, dRt;
    logic dataStall, mdStall, isStop, mdBusy;
    function automatic logic hit(input logic [TW-1:0] tUse, input logic [TW-1:0] tNew,
                                 input logic we, input logic [4:0] wReg, input logic [4:0] src);
        return (tUse < tNew) && we && (wReg != REG_ZERO) && (wReg == src);
    endfunction
    assign dRs = bus.D_inStr[RS_MSB:RS_LSB];
    assign dRt = bus.D_inStr[RT_MSB:RT_LSB];
    // W results are always forwardable, so only E and M producers can stall.
    assign dataStall = hit(bus.D_TuseRs, bus.E_Tnew, bus.E_regWrite, bus.E_writeReg, dRs)
                     | hit(bus.D_TuseRs, bus.M_Tnew, bus.M_regWrite, bus.M_writeReg, dRs)
                     | hit(bus.D_TuseRt, bus.E_Tnew, bus.E_regWrite, bus.E_writeReg, dRt)
                     | hit(bus.D_TuseRt, bus.M_Tnew, bus.M_regWrite, bus.M_writeReg, dRt);
    md_busy_tracker #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CW(CW)) tracker (
        .clk(clk), .reset(reset), .mdStart(bus.E_mdStart), .mdIsDiv(bus.E_mdIsDiv), .mdBusy(mdBusy)
    );
    assign mdStall = bus.D_isMD & mdBusy;
    assign isStop = dataStall | mdStall;
    assign bus.E_mdBusy = mdBusy;
    assign bus.F_pcWE = !isStop;
    assign bus.D_regWE = !isStop;
    assign bus.E_regclr = isStop;
`ifdef HAZARD_STALL_PERF_EN
    logic [31:0] cntData, cntMd;
    always_ff @(posedge clk)
        if (reset) begin
            cntData <= '0;
            cntMd <= '0;
        end else begin
            if (dataStall) cntData <= cntData + 32'd1;
            if (mdStall && !dataStall) cntMd <= cntMd + 32'd1;
        end
    assign bus.stallCntData = cntData;
    assign bus.stallCntMd = cntMd;
`else
    assign bus.stallCntData = '0;
    assign bus.stallCntMd = '0;
`endif
endmodule

// File: doc/hazard_stall_mdu.md
# hazard_stall_mdu

Pipeline stall controller for the five-stage MIPS core, successor to the single-cycle-ALU hazard unit. It sits beside the D stage. It compares D-stage register demand times (Tuse) against E/M producer ready times (Tnew), as the previous generation did, with parametrised time-field widths. It adds a sequential busy tracker for the multi-cycle multiply/divide unit (MDU) that stalls MDU-accessing instructions in D.

## Interface
Parameters:
- `TW`, 2, width of Tuse/Tnew fields
- `MULT_CYCLES`, 5, busy cycles after a mult/multu enters E
- `DIV_CYCLES`, 10, busy cycles after a div/divu enters E
- `CW`, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports (`name direction width meaning`):
- `clk` in 1: clock; the block has exactly one clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `D_inStr` in 32: D instruction; rs = [25:21], rt = [20:16]
- `D_TuseRs` / `D_TuseRt` in TW: cycles until D consumes rs / rt
- `D_isMD` in 1: D instruction reads or writes HI/LO or starts the MDU
- `E_writeReg`, `M_writeReg` in 5: destination register
- `E_regWrite`, `M_regWrite` in 1: stage will write its destination
- `E_Tnew`, `M_Tnew` in TW: cycles until result is available
- `E_mdStart` in 1: E holds mult/multu/div/divu this cycle
- `E_mdIsDiv` in 1: qualifies `E_mdStart`; 1 = div type
- `F_pcWE` out 1: PC write enable
- `D_regWE` out 1: F/D register write enable
- `E_regclr` out 1: flush D/E register to bubble
- `E_mdBusy` out 1: MDU busy, observable by E-stage logic
- `stallCntData`, `stallCntMd` out 32: performance counters (see Configuration)

## Operation
- Data stall, per source `s` in {rs, rt} and producer `P` in {E, M}:
  - Condition: `D_Tuse_s < P_Tnew` && `P_regWrite` && `P_writeReg != 0` && `P_writeReg == D_s`.
  - Compares are unsigned, TW bits.
  - W is never checked.
- `dataStall` = OR over all four terms.
- Busy counter `cnt` (CW bits), next-state priority:
  1. `reset` → 0.
  2. `E_mdStart` → `E_mdIsDiv ? DIV_CYCLES : MULT_CYCLES`. A restart while `cnt != 0` reloads.
  3. `cnt != 0` → `cnt - 1`.
  4. Otherwise hold at 0.
- `E_mdBusy` = `E_mdStart | (cnt != 0)`. This is combinational on `E_mdStart`, so busy is visible in the cycle the instruction sits in E.
- `mdStall` = `D_isMD & E_mdBusy`.
- `isStop` = `dataStall | mdStall`.
- Outputs:
  - `F_pcWE` = `D_regWE` = `!isStop`
  - `E_regclr` = `isStop`
- The data/MD stall outputs are purely combinational from inputs and `cnt`; no cycle of latency is added.

## Timing
- Reset values: `cnt` = 0, `E_mdBusy` = 0 (with `E_mdStart` low), `F_pcWE` = `D_regWE` = 1 and `E_regclr` = 0 (absent data hazard), perf counters = 0.
- mult in E at cycle t:
  - busy during cycles t .. t+MULT_CYCLES (`cnt` counts 5, 4, 3, 2, 1 in t+1..t+5).
  - An MD instruction in D is released at t+MULT_CYCLES+1.
- div: same pattern, with DIV_CYCLES.
- `reset` mid-count: `cnt` = 0 next cycle; busy drops unless `E_mdStart` is asserted.
- A stall does not freeze `cnt`. The MDU runs independently of the pipeline.
- Simultaneous data stall and MD stall: single stall; the outputs are identical.

## Configuration
- Macro: `HAZARD_STALL_PERF_EN`.
- Defined:
  - `stallCntData` increments each cycle `dataStall` = 1.
  - `stallCntMd` increments each cycle `mdStall & !dataStall`.
  - Both are 32-bit, wrap 0xFFFFFFFF → 0, and clear on `reset`.
- Undefined: no counter registers; both ports tied to 0.

## Structure
- Shared package `hazard_pkg`:
  - Tuse/Tnew type of TW bits
  - default MULT_CYCLES / DIV_CYCLES
  - rs/rt field bit positions
  - register-zero constant
- One sub-module, `md_busy_tracker`: the counter, reload, and `E_mdBusy`.
- The top module holds the Tuse/Tnew comparisons, stall combination, and optional perf counters.

## Test plan
- Load-use: `E_writeReg`=8, `E_regWrite`=1, `E_Tnew`=2, D rs=8, `D_TuseRs`=1 → `F_pcWE`=0, `E_regclr`=1. Same with `E_writeReg`=0 → no stall.
- M producer: `M_Tnew`=1, `D_TuseRt`=0, rt match → stall. `M_Tnew`=1, `D_TuseRt`=1 → no stall.
- mult then mfhi:
  - Stimulus: `E_mdStart`=1, `E_mdIsDiv`=0 at cycle 10; `D_isMD`=1 held.
  - Expect stall in cycles 10–15, release at 16, `E_mdBusy`=0 at 16.
- div: same stimulus with `E_mdIsDiv`=1 → stall for 11 cycles. A non-MD D instruction in the same window → no stall.
- `reset` asserted at cycle 3 of a div count → `cnt`=0 and `E_mdBusy`=0 the next cycle; outputs at reset values.
- With `HAZARD_STALL_PERF_EN`:
  - 3 data-stall cycles followed by 4 MD-only stall cycles → `stallCntData`=3, `stallCntMd`=4.
  - Counter preloaded to near max wraps to 0.
